// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: word type, small-sigma functions and the
// message-schedule FSM state encoding.
package sha_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned SHA256_ROUNDS = 64;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun
  } sched_state_e;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_sched_next.sv
// Next schedule word from the sliding-window taps. Kept as its own module so
// the four-input adder tree can be floorplanned and timed in isolation.
module sha_sched_next
  import sha_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t next
);

  assign next = ssig1(w14) + w9 + ssig0(w1) + w0;

endmodule

// File: rtl/sha_message_schedule.sv
// SHA-256 message schedule: accepts a 512-bit block, pulses comp_start, then
// streams W[0..NUM_ROUNDS-1] one word per cycle from a 16-word sliding window.
module sha_message_schedule
  import sha_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = SHA256_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         block_valid,
  output logic         block_ready,
  input  logic [511:0] block,
  output logic         comp_start,
  output logic [31:0]  w_out,
  output logic         w_valid,
  output logic [5:0]   round,
  output logic         done
);

  localparam int unsigned WindowLen = 16;
  localparam logic [5:0]  LastRound = 6'(NUM_ROUNDS - 1);

  sched_state_e state_q, state_d;
  logic [5:0]   round_q, round_d;
  word_t        window_q [WindowLen];
  word_t        next_word;
  logic         load;
  logic         shift;

  sha_sched_next u_next (
    .w0   (window_q[0]),
    .w1   (window_q[1]),
    .w9   (window_q[9]),
    .w14  (window_q[14]),
    .next (next_word)
  );

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    load        = 1'b0;
    shift       = 1'b0;
    block_ready = 1'b0;
    comp_start  = 1'b0;
    w_valid     = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        block_ready = 1'b1;
        if (block_valid) begin
          load    = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        comp_start = 1'b1;
        round_d    = '0;
        state_d    = StRun;
      end
      StRun: begin
        w_valid = 1'b1;
        shift   = 1'b1;
        if (round_q == LastRound) begin
          done        = 1'b1;
          block_ready = 1'b1;
          if (block_valid) begin
            load    = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          round_d = round_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WindowLen; i++) window_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < WindowLen; i++) window_q[i] <= block[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < WindowLen - 1; i++) window_q[i] <= window_q[i+1];
      window_q[WindowLen-1] <= next_word;
    end
  end

  assign w_out = window_q[0];
  assign round = round_q;

endmodule

// File: tb/tb_sha_message_schedule.sv
// Self-checking bench for sha_message_schedule against an array-based
// SHA-256 schedule model.
module tb_sha_message_schedule;

  logic         clk;
  logic         rst;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block;
  logic         comp_start;
  logic [31:0]  w_out;
  logic         w_valid;
  logic [5:0]   round;
  logic         done;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] ref_w [64];
  logic [31:0] cap_w [64];

  sha_message_schedule #(.NUM_ROUNDS(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block       (block),
    .comp_start  (comp_start),
    .w_out       (w_out),
    .w_valid     (w_valid),
    .round       (round),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule recurrence over a full 64-entry array.
  function automatic void build_ref(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) ref_w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3);
      s1 = rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10);
      ref_w[i] = s1 + ref_w[i-7] + s0 + ref_w[i-16];
    end
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Called at a negedge while idle; returns at the negedge of the START cycle.
  task automatic offer(input logic [511:0] blk);
    check("ready_before_offer", 64'(block_ready), 64'd1);
    block       = blk;
    block_valid = 1'b1;
    @(negedge clk);
  endtask

  // Called at the START negedge; checks the start pulse and all 64 words.
  task automatic expect_block(input logic [511:0] blk, input bit chain,
                              input logic [511:0] nxt, input bit toggle);
    block_valid = 1'b0;
    build_ref(blk);
    check("comp_start", 64'(comp_start), 64'd1);
    check("start_w_valid", 64'(w_valid), 64'd0);
    check("start_ready", 64'(block_ready), 64'd0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      cap_w[k] = w_out;
      check($sformatf("w_valid[%0d]", k), 64'(w_valid), 64'd1);
      check($sformatf("round[%0d]", k), 64'(round), 64'(k));
      check($sformatf("w[%0d]", k), 64'(w_out), 64'(ref_w[k]));
      check($sformatf("done[%0d]", k), 64'(done), 64'(k == 63));
      check($sformatf("comp_start_run[%0d]", k), 64'(comp_start), 64'd0);
      if (k == 0 || k >= 62)
        check($sformatf("ready[%0d]", k), 64'(block_ready), 64'(k == 63));
      if (toggle && k >= 10 && k <= 30) begin
        block_valid = 1'($urandom);
        block       = rand_block();
      end
      if (k == 31) block_valid = 1'b0;
      if (k == 63) begin
        block       = chain ? nxt : block;
        block_valid = chain;
      end
    end
    @(negedge clk);
    if (!chain) begin
      check("idle_ready", 64'(block_ready), 64'd1);
      check("idle_w_valid", 64'(w_valid), 64'd0);
      check("idle_comp_start", 64'(comp_start), 64'd0);
    end
  endtask

  typedef struct {
    logic [511:0] blk;
    int           idx;
    logic [31:0]  exp;
  } vec_t;

  localparam logic [511:0] AbcBlock  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] OnesBlock = {512{1'b1}};

  initial begin
    vec_t         vecs [6];
    logic [511:0] b1, b2;
    int           n;

    vecs[0] = '{AbcBlock, 0, 32'h61626380};
    vecs[1] = '{AbcBlock, 15, 32'h00000018};
    vecs[2] = '{AbcBlock, 16, 32'h61626380};
    vecs[3] = '{AbcBlock, 17, 32'h000F0000};
    vecs[4] = '{OnesBlock, 0, 32'hFFFFFFFF};
    vecs[5] = '{OnesBlock, 16, 32'h203FFFFC};

    rst         = 1'b1;
    block_valid = 1'b0;
    block       = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_w_valid", 64'(w_valid), 64'd0);
    check("rst_comp_start", 64'(comp_start), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_round", 64'(round), 64'd0);
    check("rst_w_out", 64'(w_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(block_ready), 64'd1);

    // Known-answer vectors, each also checked word-by-word against the model.
    for (int v = 0; v < 6; v++) begin
      offer(vecs[v].blk);
      expect_block(vecs[v].blk, 1'b0, '0, 1'b0);
      check($sformatf("vec%0d_w[%0d]", v, vecs[v].idx), 64'(cap_w[vecs[v].idx]),
            64'(vecs[v].exp));
    end

    // Back-to-back blocks with valid held high.
    b1 = rand_block();
    b2 = rand_block();
    offer(b1);
    expect_block(b1, 1'b1, b2, 1'b0);
    expect_block(b2, 1'b0, '0, 1'b0);

    // Valid and data wiggling during RUN must not disturb the stream.
    b1 = rand_block();
    offer(b1);
    expect_block(b1, 1'b0, '0, 1'b1);

    // Asynchronous reset at t=37, mid-cycle, with a concurrent offer.
    b1 = rand_block();
    build_ref(b1);
    offer(b1);
    block_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (round !== 6'd37 && n < 80);
    check("t37_reached", 64'(n < 80), 64'd1);
    check("t37_word", 64'(w_out), 64'(ref_w[37]));
    #2;
    rst = 1'b1;
    #1;
    check("async_w_valid", 64'(w_valid), 64'd0);
    check("async_done", 64'(done), 64'd0);
    check("async_comp_start", 64'(comp_start), 64'd0);
    check("async_round", 64'(round), 64'd0);
    block       = rand_block();
    block_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst         = 1'b0;
    block_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(block_ready), 64'd1);
    check("post_rst_comp_start", 64'(comp_start), 64'd0);
    check("post_rst_w_valid", 64'(w_valid), 64'd0);
    b1 = rand_block();
    offer(b1);
    expect_block(b1, 1'b0, '0, 1'b0);

    // Reset landing in the START cycle kills the pulse immediately.
    offer(rand_block());
    block_valid = 1'b0;
    check("start_pulse_pre", 64'(comp_start), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("start_pulse_async", 64'(comp_start), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("start_rst_idle", 64'(w_valid), 64'd0);

    // Random blocks.
    for (int r = 0; r < 3; r++) begin
      b1 = rand_block();
      offer(b1);
      expect_block(b1, 1'b0, '0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sha_message_schedule.md
Name: sha_message_schedule

Overview:
- Upstream feeder for the SHA-256 round/compressor stage.
- Accepts one 512-bit message block over a valid/ready handshake and expands it to the 64 schedule words W[0..63].
- Presents one word per cycle, aligned with the compressor's timing: a one-cycle start pulse, then W[0] on the next cycle, then one word per cycle up to W[63].
- The start pulse drives the compressor's rst input, so the compressor's round counter and hash-state load line up with W[0].

Parameters:
- NUM_ROUNDS, 64, number of words emitted per block. Fixed for SHA-256; the parameter exists only for counter sizing and test shortening.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- block_valid  in  1  a message block is offered on block
- block_ready  out  1  block is accepted when block_valid && block_ready at a clk edge
- block  in  512  message block; block[511:480] = W[0], block[31:0] = W[15] (big-endian word order)
- comp_start  out  1  one-cycle pulse, connected to the compressor rst; W[0] appears the following cycle
- w_out  out  32  current schedule word W[t]
- w_valid  out  1  w_out holds a valid W[t]
- round  out  6  t, the index of the word on w_out
- done  out  1  one-cycle pulse coincident with W[63]

Behaviour:
- Reset (async assert, sync deassert to clk):
  - state=IDLE; window, round, w_out = 0.
  - comp_start, w_valid, done = 0; block_ready = 1 after reset deasserts.
- Storage:
  - window: 16x32-bit sliding register; window[0] is always W[t].
  - next = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32, with:
    - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  - Each RUN cycle, window shifts down by one word and next enters window[15].
  - Words computed during t >= 48 are unused and harmless; no special-casing.
- w_out = window[0] (registered path); round = t counter.
- FSM:
  - IDLE: block_ready=1. On handshake, load window[i] = block[511-32i -: 32] and go to START.
  - START: comp_start=1, block_ready=0. Next cycle go to RUN with t=0.
  - RUN:
    - w_valid=1; t increments each cycle.
    - At t=NUM_ROUNDS-1: done=1, block_ready=1.
    - A handshake in that cycle loads the new block and goes to START.
    - With no handshake, go to IDLE.
- Throughput: back-to-back blocks cost NUM_ROUNDS+1 cycles each, with exactly one START gap between W[63] and the next comp_start.
- block_valid while block_ready=0 is ignored; block is not sampled. The source must hold the block until handshake.
- Latency: handshake at edge N → comp_start high in cycle N+1 → W[0] in cycle N+2 → W[63] in cycle N+65.
- round wraps only through reload (cleared to 0 on START→RUN); it never counts past NUM_ROUNDS-1.
- Reset mid-block: all of the following happen immediately and asynchronously:
  - state goes to IDLE and the in-flight block is discarded;
  - w_valid, done and comp_start go low;
  - no partial resume after reset.
- Simultaneous rst and handshake: rst wins; the block is not accepted.

Decomposition:
- Shared package sha_pkg holds:
  - WORD_W = 32 and SHA256_ROUNDS = 64;
  - typedef word_t;
  - functions ssig0/ssig1, also used by a future software-model checker;
  - the state enum for this FSM.
- Sub-module sha_sched_next: combinational next-word adder, built from the window taps 0, 1, 9 and 14. It keeps the addition tree isolated for timing.

Test Plan:
- Padded "abc" block (0x61626380, 13x 0x00000000, 0x00000018):
  - comp_start 1 cycle after handshake;
  - W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000;
  - W[0..63] match the golden model.
- Two blocks offered back-to-back (valid held high):
  - second accepted in the done cycle;
  - exactly one non-valid cycle, with comp_start=1, between W[63] and the next W[0];
  - round sequences are 0..63 twice.
- block_valid toggled during RUN (t=10..30) with changing block data → ignored; output words unchanged versus the golden model.
- rst asserted at t=37, mid-clock:
  - w_valid, done, comp_start drop without waiting for clk; block_ready=1 after deassert;
  - next block restarts cleanly at W[0].
- All-ones block (16x 0xFFFFFFFF) → every addition wraps mod 2^32; W[16..63] match the golden model.
- Integrated with the compressor, IV as inputhashstate, "abc" block → hash after round 63 plus IV = 0xBA7816BF...F20015AD.
